// File: rtl/la_rrarb4.sv
// Four-requester round-robin arbiter with registered one-hot grant, optional max hold time.
// Optional lock input enabled by defining LA_RRARB4_LOCK_EN.
//
// state    | meaning
// ST_IDLE  | no holder, gnt=0, waiting for any req
// ST_GRANT | one holder (gnt_id), grant kept, passed or released each edge
module la_rrarb4 #(
   parameter string PROP    = "DEFAULT",
   parameter int    MAXHOLD = 0
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic [3:0] req,
`ifdef LA_RRARB4_LOCK_EN
   input  logic       lock,
`endif
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       valid,
   output logic       idle
);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   localparam logic [7:0] HOLD_LAST = 8'((MAXHOLD == 0) ? 0 : MAXHOLD - 1);

   state_t     state_q, state_d;
   logic [1:0] id_q, id_d;
   logic [1:0] last_q, last_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] eff_cnt;
   logic [3:0] gnt_q, gnt_d;
   logic       valid_q, valid_d;
   logic [2:0] pick_all, pick_oth;
   logic       locked_q, locked_d;
   logic       lock_hold;

   // Returns {found, index}; search order is after+1, after+2, ... modulo 4.
   function automatic logic [2:0] pick(input logic [1:0] after, input logic [3:0] r);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = after + 2'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

`ifdef LA_RRARB4_LOCK_EN
   assign lock_hold = lock;
`else
   assign lock_hold = 1'b0;
`endif

   assign pick_all = pick(last_q, req);
   assign pick_oth = pick(last_q, req & ~(4'b0001 << id_q));
   // After a locked stretch the hold window restarts from zero.
   assign eff_cnt  = locked_q ? 8'd0 : cnt_q;

   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      locked_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_all[2]) begin
               state_d = ST_GRANT;
               id_d    = pick_all[1:0];
               last_d  = pick_all[1:0];
               cnt_d   = 8'd0;
            end
         end
         ST_GRANT: begin
            if (lock_hold) begin
               locked_d = 1'b1;
            end else if (!req[id_q]) begin
               if (pick_oth[2]) begin
                  id_d   = pick_oth[1:0];
                  last_d = pick_oth[1:0];
                  cnt_d  = 8'd0;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = 8'd0;
               end
            end else if (MAXHOLD == 0) begin
               cnt_d = 8'd0;
            end else if (eff_cnt == HOLD_LAST) begin
               cnt_d = 8'd0;
               if (pick_oth[2]) begin
                  id_d   = pick_oth[1:0];
                  last_d = pick_oth[1:0];
               end
            end else begin
               cnt_d = (eff_cnt == 8'd255) ? eff_cnt : eff_cnt + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      valid_d = (state_d == ST_GRANT);
      gnt_d   = valid_d ? (4'b0001 << id_d) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q  <= ST_IDLE;
         id_q     <= 2'd0;
         last_q   <= 2'd3;
         cnt_q    <= 8'd0;
         gnt_q    <= 4'b0000;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = id_q;
   assign valid  = valid_q;
   assign idle   = !valid_q && (req == 4'b0000);

endmodule

// File: tb/tb_la_rrarb4.sv
// Self-checking bench for la_rrarb4: three instances (MAXHOLD 0, 3, 2) sharing stimulus,
// directed table, lock sequence (when LA_RRARB4_LOCK_EN is defined) and random traffic.
module tb_la_rrarb4;

   logic       clk = 1'b0;
   logic       nreset;
   logic [3:0] req;
   logic       lock_s;
   logic [3:0] gnt_a [3];
   logic [1:0] id_a  [3];
   logic       val_a [3];
   logic       idl_a [3];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

`ifdef LA_RRARB4_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   la_rrarb4 #(.PROP("DEFAULT"), .MAXHOLD(0)) u0 (
      .clk(clk), .nreset(nreset), .req(req),
`ifdef LA_RRARB4_LOCK_EN
      .lock(lock_s),
`endif
      .gnt(gnt_a[0]), .gnt_id(id_a[0]), .valid(val_a[0]), .idle(idl_a[0]));

   la_rrarb4 #(.PROP("DEFAULT"), .MAXHOLD(3)) u3 (
      .clk(clk), .nreset(nreset), .req(req),
`ifdef LA_RRARB4_LOCK_EN
      .lock(lock_s),
`endif
      .gnt(gnt_a[1]), .gnt_id(id_a[1]), .valid(val_a[1]), .idle(idl_a[1]));

   la_rrarb4 #(.PROP("DEFAULT"), .MAXHOLD(2)) u2 (
      .clk(clk), .nreset(nreset), .req(req),
`ifdef LA_RRARB4_LOCK_EN
      .lock(lock_s),
`endif
      .gnt(gnt_a[2]), .gnt_id(id_a[2]), .valid(val_a[2]), .idle(idl_a[2]));

   // Reference model: holder index (-1 = none), last winner, cycles held in current window.
   int mh [3] = '{0, 3, 2};
   int m_h [3];
   int m_last [3];
   int m_run [3];

   function automatic int find(input int last, input logic [3:0] r, input int excl);
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (last + k) % 4;
         if (i != excl && r[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         int w;
         if (!nreset) begin
            m_h[i] = -1; m_last[i] = 3; m_run[i] = 0;
         end else if (m_h[i] < 0) begin
            w = find(m_last[i], req, -1);
            if (w >= 0) begin m_h[i] = w; m_last[i] = w; m_run[i] = 1; end
         end else if (LOCK_EN && lock_s) begin
            m_run[i] = 1;
         end else if (!req[m_h[i]] || (mh[i] > 0 && m_run[i] >= mh[i])) begin
            w = find(m_h[i], req, m_h[i]);
            if (w >= 0) begin m_h[i] = w; m_last[i] = w; m_run[i] = 1; end
            else if (!req[m_h[i]]) m_h[i] = -1;
            else m_run[i] = 1;
         end else begin
            m_run[i]++;
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_inst(input int i, input logic [3:0] expg);
      int eid;
      eid = 0;
      for (int b = 0; b < 4; b++) if (expg[b]) eid = b;
      chk($sformatf("gnt[u%0d]", i), int'(gnt_a[i]), int'(expg));
      chk($sformatf("valid[u%0d]", i), int'(val_a[i]), int'(expg != 4'b0000));
      chk($sformatf("idle[u%0d]", i), int'(idl_a[i]), int'(expg == 4'b0000 && req == 4'b0000));
      if (expg != 4'b0000) chk($sformatf("gnt_id[u%0d]", i), int'(id_a[i]), eid);
   endtask

   function automatic logic [3:0] model_gnt(input int i);
      return (m_h[i] < 0) ? 4'b0000 : (4'b0001 << m_h[i]);
   endfunction

   task automatic apply(input logic rst_n, input logic [3:0] r, input logic lk);
      nreset = rst_n; req = r; lock_s = lk;
      @(posedge clk);
      model_step();
      #1;
   endtask

   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic [3:0] g0;
      logic [3:0] g3;
   } vec_t;

   vec_t tbl [38];

   initial begin
      nreset = 1'b0; req = 4'b0000; lock_s = 1'b0;
      for (int i = 0; i < 3; i++) begin m_h[i] = -1; m_last[i] = 3; m_run[i] = 0; end
      tbl = '{
         '{0, 4'b1111, 4'b0000, 4'b0000}, '{0, 4'b1111, 4'b0000, 4'b0000},
         '{1, 4'b1111, 4'b0001, 4'b0001}, '{1, 4'b1111, 4'b0001, 4'b0001},
         '{1, 4'b1110, 4'b0010, 4'b0010}, '{1, 4'b1111, 4'b0010, 4'b0010},
         '{1, 4'b1101, 4'b0100, 4'b0100}, '{1, 4'b1111, 4'b0100, 4'b0100},
         '{1, 4'b1011, 4'b1000, 4'b1000}, '{1, 4'b1111, 4'b1000, 4'b1000},
         '{1, 4'b0111, 4'b0001, 4'b0001}, '{1, 4'b0011, 4'b0001, 4'b0001},
         '{1, 4'b0011, 4'b0001, 4'b0001}, '{1, 4'b0011, 4'b0001, 4'b0010},
         '{1, 4'b0011, 4'b0001, 4'b0010}, '{1, 4'b0011, 4'b0001, 4'b0010},
         '{1, 4'b0011, 4'b0001, 4'b0001}, '{1, 4'b0011, 4'b0001, 4'b0001},
         '{1, 4'b0011, 4'b0001, 4'b0001}, '{1, 4'b0001, 4'b0001, 4'b0001},
         '{1, 4'b0001, 4'b0001, 4'b0001}, '{1, 4'b0001, 4'b0001, 4'b0001},
         '{1, 4'b0001, 4'b0001, 4'b0001}, '{1, 4'b0001, 4'b0001, 4'b0001},
         '{1, 4'b0100, 4'b0100, 4'b0100}, '{1, 4'b0100, 4'b0100, 4'b0100},
         '{1, 4'b0100, 4'b0100, 4'b0100}, '{1, 4'b0100, 4'b0100, 4'b0100},
         '{1, 4'b0000, 4'b0000, 4'b0000}, '{1, 4'b0000, 4'b0000, 4'b0000},
         '{1, 4'b1000, 4'b1000, 4'b1000}, '{1, 4'b1000, 4'b1000, 4'b1000},
         '{0, 4'b1000, 4'b0000, 4'b0000}, '{1, 4'b1000, 4'b1000, 4'b1000},
         '{1, 4'b0000, 4'b0000, 4'b0000}, '{1, 4'b0001, 4'b0001, 4'b0001},
         '{0, 4'b1001, 4'b0000, 4'b0000}, '{1, 4'b1001, 4'b0001, 4'b0001}
      };

      for (int v = 0; v < 38; v++) begin
         apply(tbl[v].rst_n, tbl[v].req, 1'b0);
         check_inst(0, tbl[v].g0);
         check_inst(1, tbl[v].g3);
         check_inst(2, model_gnt(2));
      end

`ifdef LA_RRARB4_LOCK_EN
      apply(1'b0, 4'b0011, 1'b0);
      for (int c = 0; c < 5; c++) begin
         apply(1'b1, 4'b0011, 1'b1);
         chk("lock_hold", int'(gnt_a[2]), 1);
      end
      apply(1'b1, 4'b0011, 1'b0);
      chk("lock_drop_1", int'(gnt_a[2]), 1);
      apply(1'b1, 4'b0011, 1'b0);
      chk("lock_drop_2", int'(gnt_a[2]), 2);
      apply(1'b1, 4'b0000, 1'b1);
      chk("lock_no_req", int'(gnt_a[2]), 2);
      apply(1'b1, 4'b0000, 1'b0);
      chk("lock_release", int'(gnt_a[2]), 0);
      for (int i = 0; i < 3; i++) check_inst(i, model_gnt(i));
`endif

      for (int c = 0; c < 3000; c++) begin
         logic [3:0] r;
         logic       rn, lk;
         r  = (c % 50 < 25) ? 4'($urandom_range(0, 15)) : (req | 4'($urandom_range(0, 15) & 4'($urandom_range(0, 15))));
         if ($urandom_range(0, 3) == 0) r = r & ~(4'b0001 << $urandom_range(0, 3));
         rn = ($urandom_range(0, 149) != 0);
         lk = ($urandom_range(0, 9) == 0);
         apply(rn, r, lk);
         for (int i = 0; i < 3; i++) check_inst(i, model_gnt(i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
